// File: rtl/lcd1602_pkg.sv
// Shared definitions for the LCD1602 controller and its bus writer.
// Holds the write-cycle state encoding, the HD44780 command bytes that need
// the long execution wait, and a helper that classifies a request byte.
package lcd1602_pkg;

  typedef enum logic [2:0] {
    POWERUP = 3'd0,
    IDLE    = 3'd1,
    SETUP   = 3'd2,
    EN_HIGH = 3'd3,
    HOLD    = 3'd4,
    EXEC    = 3'd5
  } lcd_state_e;

  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_HOME       = 8'h02;
  // Return Home ignores bit 0, so 0x02 and 0x03 compare equal under this mask.
  localparam logic [7:0] LONG_EXEC_MASK = 8'hFE;

  // Clear Display and Return Home take ~1.6 ms; every other write ~40 us.
  function automatic logic is_long_exec(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || ((data & LONG_EXEC_MASK) == CMD_HOME));
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd1602_bus_writer_if.sv
// Request handshake between the LCD1602 controller (master) and the bus
// writer (slave).
//   wr_valid : request present, held until accepted
//   wr_rs    : 0 = command, 1 = character data
//   wr_data  : byte to write
//   wr_ready : writer can accept a request this cycle
//   busy     : write cycle or power-up wait in progress (~wr_ready)
interface lcd1602_bus_writer_if;

  logic       wr_valid;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       busy;

  modport master (
    output wr_valid, wr_rs, wr_data,
    input  wr_ready, busy
  );

  modport slave (
    input  wr_valid, wr_rs, wr_data,
    output wr_ready, busy
  );

endinterface

// File: rtl/lcd1602_delay_cnt.sv
// Loadable delay counter shared by every timed state of the bus writer.
//   clk   : system clock
//   reset : asynchronous active-low reset, counter returns to 0
//   load  : restart the delay (count back to 0) on the next edge
//   len   : length of the current delay in cycles (>= 1)
//   done  : high during the last cycle of the delay
// The count restarts on the edge that enters a state, so a state whose
// delay is len lasts exactly len cycles.
module lcd1602_delay_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign done = (cnt == (len - CNT_W'(1)));

endmodule

// File: rtl/lcd1602_bus_writer.sv
// HD44780 8-bit write-cycle generator for an LCD1602 module.
// Accepts one byte per handshake and drives address setup, the enable pulse,
// hold and the command-execution wait on the LCD pins, refusing further
// requests until the wait has elapsed. Also owns the power-on delay.
//   clk      : system clock (50 MHz nominal)
//   reset    : asynchronous active-low reset
//   wr       : request handshake (slave side)
//   lcd_rs   : register select, captured at accept
//   lcd_rw   : read/write, always 0 (write-only)
//   lcd_e    : enable, registered, high only while the pulse is driven
//   lcd_data : data bus, captured at accept
module lcd1602_bus_writer
  import lcd1602_pkg::*;
#(
  parameter int T_POWERUP_CYC   = 750000,
  parameter int T_SETUP_CYC     = 2,
  parameter int T_EN_CYC        = 12,
  parameter int T_HOLD_CYC      = 2,
  parameter int T_EXEC_CYC      = 2000,
  parameter int T_EXEC_LONG_CYC = 80000
) (
  input  logic                clk,
  input  logic                reset,
  lcd1602_bus_writer_if.slave wr,
  output logic                lcd_rs,
  output logic                lcd_rw,
  output logic                lcd_e,
  output logic [7:0]          lcd_data
);

  localparam int T_MAX = max_int(max_int(max_int(T_POWERUP_CYC, T_SETUP_CYC),
                                         max_int(T_EN_CYC, T_HOLD_CYC)),
                                 max_int(T_EXEC_CYC, T_EXEC_LONG_CYC));
  localparam int CNT_W = $clog2(T_MAX) + 1;

  localparam logic [2:0] S_POWERUP = POWERUP;
  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_SETUP   = SETUP;
  localparam logic [2:0] S_EN_HIGH = EN_HIGH;
  localparam logic [2:0] S_HOLD    = HOLD;
  localparam logic [2:0] S_EXEC    = EXEC;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic             long_exec;
  logic             accept;
  logic             cnt_load;
  logic             cnt_done;
  logic [CNT_W-1:0] cnt_len;

  assign accept = (state == S_IDLE) && wr.wr_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      S_POWERUP: if (cnt_done) state_nxt = S_IDLE;
      S_IDLE:    if (wr.wr_valid) state_nxt = S_SETUP;
      S_SETUP:   if (cnt_done) state_nxt = S_EN_HIGH;
      S_EN_HIGH: if (cnt_done) state_nxt = S_HOLD;
      S_HOLD:    if (cnt_done) state_nxt = S_EXEC;
      S_EXEC:    if (cnt_done) state_nxt = S_IDLE;
      default:   state_nxt = S_POWERUP;
    endcase
  end

  // Delay length of the state currently being timed; IDLE is untimed.
  always_comb begin
    cnt_len = CNT_W'(1);
    case (state)
      S_POWERUP: cnt_len = CNT_W'(T_POWERUP_CYC);
      S_SETUP:   cnt_len = CNT_W'(T_SETUP_CYC);
      S_EN_HIGH: cnt_len = CNT_W'(T_EN_CYC);
      S_HOLD:    cnt_len = CNT_W'(T_HOLD_CYC);
      S_EXEC:    cnt_len = long_exec ? CNT_W'(T_EXEC_LONG_CYC) : CNT_W'(T_EXEC_CYC);
      default:   cnt_len = CNT_W'(1);
    endcase
  end

  // Every state change restarts the delay for the state being entered.
  assign cnt_load = (state_nxt != state);

  lcd1602_delay_cnt #(
    .CNT_W (CNT_W)
  ) u_delay_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .len   (cnt_len),
    .done  (cnt_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_POWERUP;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= 8'h00;
      long_exec <= 1'b0;
    end else begin
      state <= state_nxt;
      lcd_e <= (state_nxt == S_EN_HIGH);
      // RS/DATA are held through IDLE until the next accepted byte.
      if (accept) begin
        lcd_rs    <= wr.wr_rs;
        lcd_data  <= wr.wr_data;
        long_exec <= is_long_exec(wr.wr_rs, wr.wr_data);
      end
    end
  end

  assign wr.wr_ready = (state == S_IDLE);
  assign wr.busy     = (state != S_IDLE);
  assign lcd_rw      = 1'b0;

endmodule

// File: tb/tb_lcd1602_bus_writer.sv
module tb_lcd1602_bus_writer;

  localparam int TPU = 10;
  localparam int TS  = 2;
  localparam int TE  = 3;
  localparam int TH  = 2;
  localparam int TX  = 5;
  localparam int TXL = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data;

  int checks = 0;
  int errors = 0;

  lcd1602_bus_writer_if bus_if ();

  lcd1602_bus_writer #(
    .T_POWERUP_CYC   (TPU),
    .T_SETUP_CYC     (TS),
    .T_EN_CYC        (TE),
    .T_HOLD_CYC      (TH),
    .T_EXEC_CYC      (TX),
    .T_EXEC_LONG_CYC (TXL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr       (bus_if),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .lcd_data (lcd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Timeline model: every accepted byte fixes, in edge numbers counted from
  // reset release, when E rises, when it falls and when ready returns.
  function automatic bit long_cmd(input logic rs, input logic [7:0] d);
    return (rs == 1'b0) && (d == 8'h01 || d == 8'h02 || d == 8'h03);
  endfunction

  int         edge_n = 0;
  int         ready_edge = TPU;
  int         e_rise = -1;
  int         e_fall = -1;
  logic       m_rs = 1'b0;
  logic [7:0] m_data = 8'h00;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_n     <= 0;
      ready_edge <= TPU;
      e_rise     <= -1;
      e_fall     <= -1;
      m_rs       <= 1'b0;
      m_data     <= 8'h00;
    end else begin
      edge_n <= edge_n + 1;
      if (edge_n >= ready_edge && bus_if.wr_valid) begin
        m_rs       <= bus_if.wr_rs;
        m_data     <= bus_if.wr_data;
        e_rise     <= edge_n + 1 + TS;
        e_fall     <= edge_n + 1 + TS + TE;
        ready_edge <= edge_n + 1 + TS + TE + TH + (long_cmd(bus_if.wr_rs, bus_if.wr_data) ? TXL : TX);
      end
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_ready", int'(bus_if.wr_ready), int'(edge_n >= ready_edge));
      chk("cyc_busy", int'(bus_if.busy), int'(edge_n < ready_edge));
      chk("cyc_lcd_e", int'(lcd_e), int'(edge_n >= e_rise && edge_n < e_fall));
      chk("cyc_lcd_rs", int'(lcd_rs), int'(m_rs));
      chk("cyc_lcd_data", int'(lcd_data), int'(m_data));
      chk("cyc_lcd_rw", int'(lcd_rw), 0);
    end
  end

  // Called at a falling edge. Waits for ready, issues one request, then
  // measures edges from accept to ready and the E pulse it produced.
  task automatic do_write(input logic rs, input logic [7:0] d, input bit disturb,
                          output int gap, output int e_cyc, output int e_first);
    int w;
    w = 0;
    gap = 0;
    e_cyc = 0;
    e_first = -1;
    while (!bus_if.wr_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      chk("wait_ready_timeout", w, 0);
    end else begin
      bus_if.wr_valid = 1'b1;
      bus_if.wr_rs    = rs;
      bus_if.wr_data  = d;
      @(negedge clk);
      bus_if.wr_valid = 1'b0;
      bus_if.wr_data  = 8'hA5;
      while (gap < 200) begin
        @(negedge clk);
        gap++;
        if (lcd_e) begin
          e_cyc++;
          if (e_first < 0) e_first = gap;
          chk("e_pulse_data", int'(lcd_data), int'(d));
        end
        if (disturb && gap == 3) begin
          bus_if.wr_valid = 1'b1;
          bus_if.wr_data  = 8'hFF;
        end
        if (disturb && gap == 8) bus_if.wr_valid = 1'b0;
        if (bus_if.wr_ready) break;
      end
      if (gap >= 200) chk("accept_ready_timeout", gap, 0);
    end
  endtask

  int gap, e_cyc, e_first, j, e_seen;

  initial begin
    bus_if.wr_valid = 1'b1;
    bus_if.wr_rs    = 1'b1;
    bus_if.wr_data  = 8'h41;
    #1 reset = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(bus_if.wr_ready), 0);
    chk("rst_busy", int'(bus_if.busy), 1);
    chk("rst_lcd_e", int'(lcd_e), 0);
    chk("rst_lcd_data", int'(lcd_data), 0);
    chk("rst_lcd_rs", int'(lcd_rs), 0);

    // 1: power-up wait with a request already pending
    reset = 1'b1;
    j = 0;
    e_seen = 0;
    while (!bus_if.wr_ready && j < 200) begin
      @(negedge clk);
      j++;
      if (lcd_e) e_seen++;
    end
    bus_if.wr_valid = 1'b0;
    chk("s1_powerup_edges", j, 10);
    chk("s1_no_e", e_seen, 0);

    // 2: data 'A'
    do_write(1'b1, 8'h41, 1'b0, gap, e_cyc, e_first);
    chk("s2_gap", gap, 12);
    chk("s2_e_cycles", e_cyc, 3);
    chk("s2_e_first", e_first, 2);
    chk("s2_lcd_rs", int'(lcd_rs), 1);
    chk("s2_lcd_data_idle", int'(lcd_data), 8'h41);

    // 3: Clear, Home (0x03), Function Set back-to-back
    do_write(1'b0, 8'h01, 1'b0, gap, e_cyc, e_first);
    chk("s3_clear_gap", gap, 27);
    do_write(1'b0, 8'h03, 1'b0, gap, e_cyc, e_first);
    chk("s3_home_gap", gap, 27);
    do_write(1'b0, 8'h38, 1'b0, gap, e_cyc, e_first);
    chk("s3_fset_gap", gap, 12);
    chk("s3_fset_e_cycles", e_cyc, 3);

    // 4: request with changed data during the enable pulse
    do_write(1'b0, 8'h5A, 1'b1, gap, e_cyc, e_first);
    chk("s4_gap", gap, 12);
    chk("s4_e_cycles", e_cyc, 3);
    chk("s4_lcd_data", int'(lcd_data), 8'h5A);

    // 5: reset during the enable pulse
    bus_if.wr_valid = 1'b1;
    bus_if.wr_rs    = 1'b0;
    bus_if.wr_data  = 8'h0C;
    @(negedge clk);
    bus_if.wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("s5_e_before", int'(lcd_e), 1);
    #2 reset = 1'b0;
    #1;
    chk("s5_e_async", int'(lcd_e), 0);
    chk("s5_data_async", int'(lcd_data), 0);
    chk("s5_ready_async", int'(bus_if.wr_ready), 0);
    chk("s5_busy_async", int'(bus_if.busy), 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    j = 0;
    while (!bus_if.wr_ready && j < 200) begin
      @(negedge clk);
      j++;
    end
    chk("s5_powerup_edges", j, 10);

    // 6: character 0x01 takes the short wait
    do_write(1'b1, 8'h01, 1'b0, gap, e_cyc, e_first);
    chk("s6_gap", gap, 12);
    chk("s6_lcd_rs", int'(lcd_rs), 1);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
